mem_req_sequencer: RTL and testbench

- Upstream master for the 32x8 memory: sits between a request source and the memory's read/write/addr/data_in/data_out pins.
- Accepts read and write requests through a valid/ready handshake and queues them in a small FIFO.
- Plays each request out as a fixed multi-cycle strobe sequence, then returns read data through a response handshake.
- Replaces task-driven stimulus with synthesizable sequencing, so the same block can serve as bench driver and on-chip memory client.

---
 rtl/mem_req_sequencer_pkg.sv | 23 ++
 rtl/mem_req_sequencer_fifo.sv | 45 ++++
 rtl/mem_req_sequencer.sv | 148 ++++++++++++++
 tb/tb_mem_req_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_sequencer_pkg.sv
// Shared widths, request record and sequencer state encoding for mem_req_sequencer.
package mem_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        GAP,
        VFY_ISSUE,
        VFY_WAIT
    } mem_seq_state_e;

endpackage

// File: rtl/mem_req_sequencer_fifo.sv
// Request queue for mem_req_sequencer: synchronous FIFO of mem_req_t with extra-bit pointers.
module mem_req_fifo import mem_pkg::*; #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_push,
    input  mem_req_t i_data,
    input  logic     i_pop,
    output mem_req_t o_data,
    output logic     o_full,
    output logic     o_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    mem_req_t         r_mem [FIFO_DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Same index with differing wrap bits means the writer has lapped the reader.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign o_data    = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end

endmodule

// File: rtl/mem_req_sequencer.sv
// Queued read/write master for the 32x8 memory; MEM_REQ_WRITE_VERIFY_EN adds a read-back check after each write.
// state     | meaning
// IDLE      | pop next request when the queue is non-empty
// ISSUE     | one-cycle read or write strobe
// WAIT      | memory registers read data; reads capture it at cycle end
// RESP      | hold response until rsp_ready
// GAP       | one-cycle bus turnaround
// VFY_ISSUE | read strobe of the address just written
// VFY_WAIT  | compare read-back against written data
module mem_req_sequencer #(
    parameter int ADDR_W     = mem_pkg::ADDR_W,
    parameter int DATA_W     = mem_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              err_mismatch,
    output logic [ADDR_W-1:0] err_addr
);
    import mem_pkg::*;

    mem_seq_state_e    r_state;
    mem_seq_state_e    w_state_next;
    mem_req_t          w_req_in;
    mem_req_t          w_head;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              r_op_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_rsp_addr;
    logic [DATA_W-1:0] r_rsp_rdata;
`ifdef MEM_REQ_WRITE_VERIFY_EN
    logic              r_vfy_pend;
    logic              r_err;
    logic [ADDR_W-1:0] r_err_addr;
`endif

    assign w_req_in = '{write: req_write, addr: req_addr, wdata: req_wdata};
    assign w_push   = req_valid && !w_full;
    assign w_pop    = (r_state == IDLE) && !w_empty;

    mem_req_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_req_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (!w_empty) w_state_next = ISSUE;
            ISSUE:     w_state_next = WAIT;
            WAIT:      w_state_next = r_op_write ? GAP : RESP;
            RESP:      if (rsp_ready) w_state_next = GAP;
`ifdef MEM_REQ_WRITE_VERIFY_EN
            GAP:       w_state_next = r_vfy_pend ? VFY_ISSUE : IDLE;
            VFY_ISSUE: w_state_next = VFY_WAIT;
            VFY_WAIT:  w_state_next = GAP;
`else
            GAP:       w_state_next = IDLE;
`endif
            default:   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op_write  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_addr  <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                r_op_write <= w_head.write;
                r_addr     <= w_head.addr;
                r_wdata    <= w_head.wdata;
            end
            if (r_state == WAIT && !r_op_write) begin
                r_rsp_addr  <= r_addr;
                r_rsp_rdata <= data_out;
            end
        end
    end

`ifdef MEM_REQ_WRITE_VERIFY_EN
    // The pending flag separates the post-write GAP from the post-verify GAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vfy_pend <= 1'b0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            if (w_pop)                r_vfy_pend <= w_head.write;
            else if (r_state == GAP)  r_vfy_pend <= 1'b0;
            if (r_state == VFY_WAIT && data_out != r_wdata && !r_err) begin
                r_err      <= 1'b1;
                r_err_addr <= r_addr;
            end
        end
    end

    assign read         = (r_state == ISSUE && !r_op_write) || (r_state == VFY_ISSUE);
    assign err_mismatch = r_err;
    assign err_addr     = r_err_addr;
`else
    assign read         = (r_state == ISSUE) && !r_op_write;
    assign err_mismatch = 1'b0;
    assign err_addr     = '0;
`endif

    assign write     = (r_state == ISSUE) && r_op_write;
    assign addr      = r_addr;
    assign data_in   = r_wdata;
    assign req_ready = !w_full;
    assign rsp_valid = (r_state == RESP);
    assign rsp_addr  = r_rsp_addr;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Bench for mem_req_sequencer: directed cases plus randomized traffic against a timeline model.
module tb_mem_req_sequencer;
    import mem_pkg::*;

    localparam int DEPTH = 4;
`ifdef MEM_REQ_WRITE_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif
    localparam int WR_LEN = VFY ? 7 : 4;
    localparam int RD_LEN = 5;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [4:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [4:0] rsp_addr;
    logic [7:0] rsp_rdata;
    logic       read;
    logic       write;
    logic [4:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       busy;
    logic       err_mismatch;
    logic [4:0] err_addr;

    mem_req_sequencer #(.ADDR_W(5), .DATA_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk), .rst_n (rst_n),
        .req_valid (req_valid), .req_ready (req_ready), .req_write (req_write),
        .req_addr (req_addr), .req_wdata (req_wdata),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_addr (rsp_addr), .rsp_rdata (rsp_rdata),
        .read (read), .write (write), .addr (addr), .data_in (data_in), .data_out (data_out),
        .busy (busy), .err_mismatch (err_mismatch), .err_addr (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory the DUT drives; address 12 can be made to store inverted data.
    logic [7:0] mem [32];
    bit         corrupt_en = 1'b0;
    always @(posedge clk) begin
        if (write) mem[addr] = (corrupt_en && addr == 5'd12) ? (data_in ^ 8'hFF) : data_in;
        if (read) data_out <= mem[addr];
    end

    int   rdy_mode  = 0;
    logic rdy_fixed = 1'b1;
    always @(posedge clk) begin
        #1;
        rsp_ready = (rdy_mode == 0) ? rdy_fixed : ($urandom_range(0, 2) != 0);
    end

    // Reference: a queue plus the age of the request in flight, counted in cycles since its pop.
    mem_req_t   mq[$];
    mem_req_t   m_cur;
    bit         m_act;
    int         m_age;
    bit         m_acc;
    logic [4:0] m_addr, m_rsp_addr, m_err_addr;
    logic [7:0] m_wdata, m_rsp_data;
    bit         m_err;
    logic [7:0] ref_mem [32];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_act = 0; m_age = 0; m_err = 0;
            m_addr = '0; m_wdata = '0; m_rsp_addr = '0; m_rsp_data = '0; m_err_addr = '0;
        end else begin
            m_acc = req_valid && (mq.size() < DEPTH);
            if (m_act) begin
                if (!(!m_cur.write && m_age == 3 && !rsp_ready)) begin
                    if (m_cur.write && m_age == 1)
                        ref_mem[m_cur.addr] = (corrupt_en && m_cur.addr == 5'd12) ? (m_cur.wdata ^ 8'hFF) : m_cur.wdata;
                    if (!m_cur.write && m_age == 2) begin
                        m_rsp_addr = m_cur.addr;
                        m_rsp_data = ref_mem[m_cur.addr];
                    end
                    if (VFY && m_cur.write && m_age == 5 && ref_mem[m_cur.addr] != m_cur.wdata && !m_err) begin
                        m_err      = 1;
                        m_err_addr = m_cur.addr;
                    end
                    m_age++;
                    if (m_age == (m_cur.write ? WR_LEN : RD_LEN)) m_act = 0;
                end
            end else if (mq.size() != 0) begin
                m_cur   = mq.pop_front();
                m_act   = 1;
                m_age   = 1;
                m_addr  = m_cur.addr;
                m_wdata = m_cur.wdata;
            end
            if (m_acc) mq.push_back('{write: req_write, addr: req_addr, wdata: req_wdata});
        end
    end

    bit e_read, e_write, e_rsp, e_busy, e_rdy;
    always @(negedge clk) begin
        if (rst_n) begin
            e_write = m_act && m_cur.write && (m_age == 1);
            e_read  = m_act && ((!m_cur.write && m_age == 1) || (VFY && m_cur.write && m_age == 4));
            e_rsp   = m_act && !m_cur.write && (m_age == 3);
            e_busy  = m_act || (mq.size() != 0);
            e_rdy   = (mq.size() < DEPTH);
            chk("read", 32'(read), 32'(e_read));
            chk("write", 32'(write), 32'(e_write));
            chk("addr", 32'(addr), 32'(m_addr));
            if (e_write) chk("data_in", 32'(data_in), 32'(m_wdata));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
            chk("rsp_addr", 32'(rsp_addr), 32'(m_rsp_addr));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rsp_data));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("req_ready", 32'(req_ready), 32'(e_rdy));
            chk("err_mismatch", 32'(err_mismatch), 32'(m_err));
            chk("err_addr", 32'(err_addr), 32'(m_err_addr));
        end
    end

    logic [4:0] wlog_addr[$];
    logic [7:0] wlog_data[$];
    int         wlog_cyc[$];
    int         rsp_cycles = 0;
    always @(negedge clk) begin
        if (rst_n && write) begin
            wlog_addr.push_back(addr);
            wlog_data.push_back(data_in);
            wlog_cyc.push_back(cyc);
        end
        if (rst_n && rsp_valid) rsp_cycles++;
    end

    task automatic wlog_clear();
        wlog_addr.delete();
        wlog_data.delete();
        wlog_cyc.delete();
    endtask

    task automatic push(input bit w, input logic [4:0] a, input logic [7:0] d, output int acc_cyc);
        int n;
        bit acc;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        n = 0; acc = 0; acc_cyc = 0;
        while (!acc && n < 60) begin
            @(negedge clk);
            acc     = req_ready;
            acc_cyc = cyc;
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b0;
        chk("push_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy || m_act || mq.size() != 0) && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c_tmp, c_rd, n, r0;
        int c_acc[5];
        bit found;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 32; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;

        // write 5/A7 then read it back from an idle sequencer
        wlog_clear();
        push(1'b1, 5'd5, 8'hA7, c_tmp);
        wait_idle(40);
        chk("t1_wr_pulses", 32'(wlog_addr.size()), 32'd1);
        chk("t1_wr_addr", 32'(wlog_addr[0]), 32'd5);
        chk("t1_wr_data", 32'(wlog_data[0]), 32'hA7);
        push(1'b0, 5'd5, 8'h00, c_rd);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
        chk("t1_rsp_latency", 32'(cyc - c_rd), 32'd4);
        chk("t1_rsp_addr", 32'(rsp_addr), 32'd5);
        chk("t1_rsp_rdata", 32'(rsp_rdata), 32'hA7);
        wait_idle(40);

        // five back-to-back writes
        wlog_clear();
        for (int i = 0; i < 5; i++) push(1'b1, 5'(i + 1), 8'(8'h10 + i), c_acc[i]);
        chk("t2_accept_span", 32'(c_acc[4] - c_acc[0]), 32'd4);
        @(negedge clk);
        chk("t2_full_ready", 32'(req_ready), 32'd0);
        wait_idle(100);
        chk("t2_wr_count", 32'(wlog_addr.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("t2_wr_addr", 32'(wlog_addr[i]), 32'(i + 1));
            chk("t2_wr_data", 32'(wlog_data[i]), 32'(8'h10 + i));
        end
        for (int i = 1; i < 5; i++) chk("t2_wr_spacing", 32'(wlog_cyc[i] - wlog_cyc[i-1]), 32'(WR_LEN));

        // read 31 under 10 cycles of response backpressure
        push(1'b1, 5'd31, 8'h5E, c_tmp);
        wait_idle(40);
        wlog_clear();
        rdy_fixed = 1'b0;
        push(1'b0, 5'd31, 8'h00, c_tmp);
        push(1'b1, 5'd2, 8'h11, c_tmp);
        push(1'b1, 5'd4, 8'h22, c_tmp);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_valid", 32'(rsp_valid), 32'd1);
            chk("t3_hold_addr", 32'(rsp_addr), 32'd31);
            chk("t3_hold_rdata", 32'(rsp_rdata), 32'h5E);
            chk("t3_hold_nostrobe", 32'(write | read), 32'd0);
            @(negedge clk);
        end
        chk("t3_no_issue", 32'(wlog_addr.size()), 32'd0);
        rdy_fixed = 1'b1;
        wait_idle(60);
        chk("t3_wr_count", 32'(wlog_addr.size()), 32'd2);
        chk("t3_wr_first", 32'(wlog_addr[0]), 32'd2);
        chk("t3_wr_second", 32'(wlog_addr[1]), 32'd4);

        // reset during ISSUE of a read with two writes queued behind it
        wlog_clear();
        rdy_fixed = 1'b0;
        push(1'b0, 5'd7, 8'h00, c_tmp);
        push(1'b0, 5'd9, 8'h00, c_tmp);
        push(1'b1, 5'd20, 8'h66, c_tmp);
        push(1'b1, 5'd21, 8'h77, c_tmp);
        rdy_fixed = 1'b1;
        found = 0; n = 0;
        while (!found && n < 40) begin
            @(negedge clk); n++;
            found = m_act && !m_cur.write && m_age == 1 && m_cur.addr == 5'd9;
        end
        chk("t4_reached_issue", 32'(found), 32'd1);
        chk("t4_read_before", 32'(read), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_read", 32'(read), 32'd0);
        chk("t4_rst_write", 32'(write), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t4_rst_req_ready", 32'(req_ready), 32'd1);
        chk("t4_rst_addr", 32'(addr), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        r0 = rsp_cycles;
        repeat (15) @(posedge clk);
        #1;
        chk("t4_no_rsp_after", 32'(rsp_cycles - r0), 32'd0);
        chk("t4_dropped_writes", 32'(wlog_addr.size()), 32'd0);
        chk("t4_busy_after", 32'(busy), 32'd0);

        // randomized traffic with random response backpressure
        rdy_mode = 1;
        for (int i = 0; i < 250; i++) begin
            push(1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom), c_tmp);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        rdy_mode  = 0;
        rdy_fixed = 1'b1;
        wait_idle(300);

`ifdef MEM_REQ_WRITE_VERIFY_EN
        chk("t6_err_clean", 32'(err_mismatch), 32'd0);
        corrupt_en = 1'b1;
        push(1'b1, 5'd12, 8'h3C, c_tmp);
        wait_idle(40);
        chk("t6_err_set", 32'(err_mismatch), 32'd1);
        chk("t6_err_addr", 32'(err_addr), 32'd12);
        push(1'b1, 5'd3, 8'h55, c_tmp);
        wait_idle(40);
        chk("t6_err_sticky", 32'(err_mismatch), 32'd1);
        chk("t6_err_addr_kept", 32'(err_addr), 32'd12);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
